// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - write/read handshake bundle between the register stage and the port FIFO.
interface router_fifo_if #(parameter int WIDTH = 8);
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             hdr_out;
  logic             pkt_done;
  logic             full;
  logic             empty;
  logic             overflow;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, hdr_out, pkt_done, full, empty, overflow
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, hdr_out, pkt_done, full, empty, overflow
  );
endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-port packet FIFO with header tags and parity-read pulse.
// Optional sticky write-while-full flag: define ROUTER_FIFO_OVF_EN.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  input logic          soft_reset,
  router_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic [6:0]     pkt_cnt;
  logic [WIDTH:0] rd_word;
  logic           wr_ok;
  logic           rd_ok;

  assign bus.empty = (wptr == rptr);
  assign bus.full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr_ok     = bus.write_enb && !bus.full;
  assign rd_ok     = bus.read_enb && !bus.empty;
  assign rd_word   = mem[rptr[AW-1:0]];

  // A flush leaves the array intact; only a hard reset scrubs it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!soft_reset && wr_ok) begin
      mem[wptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || soft_reset) begin
      wptr         <= '0;
      rptr         <= '0;
      pkt_cnt      <= '0;
      bus.data_out <= '0;
      bus.hdr_out  <= 1'b0;
      bus.pkt_done <= 1'b0;
    end else begin
      bus.pkt_done <= 1'b0;
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) begin
        rptr         <= rptr + PTR_ONE;
        bus.data_out <= rd_word[WIDTH-1:0];
        bus.hdr_out  <= rd_word[WIDTH];
        // Header length field counts payload bytes; +1 covers the parity byte.
        if (rd_word[WIDTH]) begin
          pkt_cnt <= {1'b0, rd_word[7:2]} + 7'd1;
        end else if (pkt_cnt != 7'd0) begin
          pkt_cnt      <= pkt_cnt - 7'd1;
          bus.pkt_done <= (pkt_cnt == 7'd1);
        end
      end
    end
  end

`ifdef ROUTER_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.write_enb && bus.full && !soft_reset) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed vector bench for router_fifo.
module tb_router_fifo;
  logic clk = 1'b0;
  logic reset;
  logic soft_reset;
  int   checks = 0;
  int   errors = 0;

`ifdef ROUTER_FIFO_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       lfd;
    logic [7:0] din;
    logic       re;
    logic       srst;
    logic [7:0] dout;
    logic       hdr;
    logic       done;
    logic       emp;
    logic       ful;
  } vec_t;

  vec_t vt [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic lfd, input logic [7:0] din,
                       input logic re, input logic srst);
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    bus.read_enb  = re;
    soft_reset    = srst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    //        we lfd din    re srst dout  hdr done emp ful
    vt[0]  = '{1, 1, 8'h0A, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 8'h01, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[2]  = '{1, 0, 8'h03, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[3]  = '{1, 0, 8'h08, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 8'h00, 1, 0, 8'h0A, 1, 0, 0, 0};
    vt[5]  = '{0, 0, 8'h00, 1, 0, 8'h01, 0, 0, 0, 0};
    vt[6]  = '{0, 0, 8'h00, 1, 0, 8'h03, 0, 0, 0, 0};
    vt[7]  = '{0, 0, 8'h00, 1, 0, 8'h08, 0, 1, 1, 0};
    vt[8]  = '{0, 0, 8'h00, 0, 0, 8'h08, 0, 0, 1, 0};
    vt[9]  = '{0, 0, 8'h00, 1, 0, 8'h08, 0, 0, 1, 0};
    vt[10] = '{1, 1, 8'h0A, 0, 0, 8'h08, 0, 0, 0, 0};
    vt[11] = '{1, 0, 8'h01, 0, 0, 8'h08, 0, 0, 0, 0};
    vt[12] = '{1, 0, 8'h02, 0, 0, 8'h08, 0, 0, 0, 0};
    vt[13] = '{1, 0, 8'h05, 0, 0, 8'h08, 0, 0, 0, 0};
    vt[14] = '{0, 0, 8'h00, 1, 0, 8'h0A, 1, 0, 0, 0};
    vt[15] = '{0, 0, 8'h00, 1, 0, 8'h01, 0, 0, 0, 0};
    vt[16] = '{0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 1, 0};
    vt[17] = '{1, 1, 8'h06, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[18] = '{1, 0, 8'h11, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[19] = '{1, 0, 8'h22, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[20] = '{0, 0, 8'h00, 1, 0, 8'h06, 1, 0, 0, 0};
    vt[21] = '{0, 0, 8'h00, 1, 0, 8'h11, 0, 0, 0, 0};
    vt[22] = '{0, 0, 8'h00, 1, 0, 8'h22, 0, 1, 1, 0};
    vt[23] = '{1, 0, 8'h33, 1, 0, 8'h22, 0, 0, 0, 0};
    vt[24] = '{0, 0, 8'h00, 1, 0, 8'h33, 0, 0, 1, 0};

    reset = 1'b0;
    hard_reset();
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_dout", bus.data_out, 8'h00);
    chk("rst_hdr", bus.hdr_out, 0);
    chk("rst_done", bus.pkt_done, 0);
    chk("rst_ovf", bus.overflow, 0);

    for (int i = 0; i < 25; i++) begin
      drive(vt[i].we, vt[i].lfd, vt[i].din, vt[i].re, vt[i].srst);
      step();
      chk($sformatf("vec%0d_dout", i), bus.data_out, vt[i].dout);
      chk($sformatf("vec%0d_hdr", i), bus.hdr_out, vt[i].hdr);
      chk($sformatf("vec%0d_done", i), bus.pkt_done, vt[i].done);
      chk($sformatf("vec%0d_empty", i), bus.empty, vt[i].emp);
      chk($sformatf("vec%0d_full", i), bus.full, vt[i].ful);
    end

    hard_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      step();
      chk($sformatf("fill%0d_full", i), bus.full, (i == 15));
    end
    chk("fill_ovf_before", bus.overflow, 0);
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    step();
    chk("fill_extra_full", bus.full, 1);
    chk("fill_ovf_set", bus.overflow, OVF);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step();
      chk($sformatf("drain%0d_dout", i), bus.data_out, 8'(i));
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_ovf_hold", bus.overflow, OVF);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("ovf_after_soft", bus.overflow, OVF);
    hard_reset();
    chk("ovf_after_reset", bus.overflow, 0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 8'(8'h48 + k), 1'b1, 1'b0);
      step();
      chk($sformatf("wrap%0d_dout", k), bus.data_out, 8'(8'h40 + k));
      chk($sformatf("wrap%0d_flags", k), {bus.full, bus.empty}, 2'b00);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step();
      chk($sformatf("wrap_tail%0d_dout", k), bus.data_out, 8'(8'h54 + k));
    end
    chk("wrap_empty", bus.empty, 1);

    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port packet buffer that sits directly downstream of the router register stage. It captures the byte stream the register stage drives (header, payload, parity) into a DEPTH-entry FIFO. Each entry carries a header tag taken from `lfd_state`. On the read side it tracks packet boundaries by loading a byte counter from each header it reads out, and signals the read of the final (parity) byte.

## Interface
- `DEPTH`, 16: number of entries; power of two, 4..64.
- `WIDTH`, 8: data byte width; the stored word is WIDTH+1 bits (bit WIDTH = header tag).
- `clk`  input  1  clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset; one clock and reset only.
- `soft_reset`  input  1  synchronous, active-high flush (e.g. read timeout); priority below `reset`.
- `write_enb`  input  1  write request for `data_in`.
- `lfd_state`  input  1  tags the byte written this cycle as a header.
- `data_in`  input  WIDTH  byte from the register stage `dout`.
- `read_enb`  input  1  read request.
- `data_out`  output  WIDTH  registered read data.
- `hdr_out`  output  1  registered header tag of the word in `data_out`.
- `pkt_done`  output  1  one-cycle pulse: the word just presented on `data_out` is the last byte (parity) of its packet.
- `full`  output  1  DEPTH words stored.
- `empty`  output  1  zero words stored.
- `overflow`  output  1  sticky write-while-full flag (see Configuration).

## Operation
- Storage: DEPTH x (WIDTH+1) array. Write and read pointers are log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- `empty` = pointers equal. `full` = low bits equal and MSBs differ. Both are combinational from the registered pointers.
- Write accepted when `write_enb && !full`: mem[wptr] <= {lfd_state, data_in}; wptr++.
- Read accepted when `read_enb && !empty`: {hdr_out, data_out} <= mem[rptr]; rptr++.
- Read not accepted: `data_out` and `hdr_out` hold their values.
- Packet counter `pkt_cnt` (7 bits), updated on accepted reads only:
  - Header word read: `pkt_cnt` <= data[7:2] + 1 (payload length plus parity).
  - Non-header word read with `pkt_cnt` != 0: `pkt_cnt`--. If `pkt_cnt` was 1, `pkt_done` is 1 in the next cycle.
  - Non-header word read with `pkt_cnt` == 0: the data is returned, the counter stays 0, and there is no pulse.
- `pkt_done` is registered and is 0 in every other cycle.
- Simultaneous read and write:
  - Neither full nor empty: both happen; occupancy unchanged.
  - Full: the read happens and the write is dropped, because `full` is sampled before the edge.
  - Empty: the write happens and the read is ignored. Data is not bypassed to the read side.
- `soft_reset`: wptr, rptr, `pkt_cnt`, `data_out`, `hdr_out` and `pkt_done` go to 0. Memory contents are retained but unreachable. Writes and reads in the same cycle are ignored.
- `reset`: as `soft_reset`, and additionally clears all memory entries and `overflow`.
- Reset values: `data_out`=0, `hdr_out`=0, `pkt_done`=0, `full`=0, `empty`=1, `overflow`=0.

## Timing
- Write to `empty` deassert: 1 cycle (visible after the accepting edge).
- Read latency: data is on `data_out` in the cycle after the edge that accepts `read_enb`.
- `pkt_done` is coincident with the parity byte on `data_out`.
- Full throughput: one write and one read per cycle.
- Reset or flush asserted in the middle of a packet: takes effect at that edge. The next packet starts with `pkt_cnt` = 0.

## Configuration
- `ROUTER_FIFO_OVF_EN` defined: `overflow` sets to 1 on any edge with `write_enb && full && !soft_reset`. It stays set until `reset`; `soft_reset` does not clear it.
- `ROUTER_FIFO_OVF_EN` undefined: `overflow` is tied to 0 and no flag register is built. The port is always present.

## Test plan
- Reset then idle: `reset`=1 for 1 cycle -> `empty`=1, `full`=0, `data_out`=0x00, `pkt_done`=0, `overflow`=0.
- Single packet:
  - Stimulus: write 0x0A (`lfd_state`=1), then 0x01, 0x03, parity 0x08. Then `read_enb`=1 for 4 cycles.
  - Required response: `data_out` = 0x0A (`hdr_out`=1), 0x01, 0x03, 0x08. `pkt_done`=1 only with 0x08. `empty`=1 afterwards.
- Fill to full: 16 writes of 0x00..0x0F -> `full`=1 after the 16th. A 17th write of 0xFF is dropped. 16 reads return 0x00..0x0F in order.
- Wrap and simultaneous access:
  - Stimulus: pre-load 8 words, then 20 cycles with both `write_enb` and `read_enb` asserted and incrementing data.
  - Required response: order preserved across the pointer wrap; occupancy stays 8; neither `full` nor `empty` asserts.
- `soft_reset` in the middle of a packet:
  - Stimulus: after reading the header 0x0A and 1 payload byte, pulse `soft_reset`.
  - Required response: `empty`=1 and `data_out`=0. A following packet with header 0x06 (len 1) gives `pkt_done` on its 2nd byte after the header.
- Overflow (with `ROUTER_FIFO_OVF_EN`):
  - Stimulus: fill to full, then write once more.
  - Required response: `overflow`=1; it remains 1 through `soft_reset` and clears on `reset`. Without the macro, `overflow` stays 0.
